// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  // One prefetch slot: address of the following instruction plus the word itself.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: registered entries, push/pop, synchronous clear that wins over push.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [ENTRY_W-1:0]       head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack into a prefetch
// queue, and drops the in-flight word when a branch redirects mid-request.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   discard_addr_q, discard_addr_d;

  logic          q_push, q_pop, q_clear;
  logic          q_full, q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  push_entry;

  logic          req_c;
  logic [31:0]   addr_c;

  assign push_entry = make_entry(fetch_pc_q + PC_STEP, imem_rdata);

  // Next-state, PC and queue control; a branch overrides freeze, ack and pop.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    discard_addr_d = discard_addr_q;
    q_push         = 1'b0;
    q_pop          = 1'b0;
    q_clear        = 1'b0;
    req_c          = 1'b0;
    addr_c         = fetch_pc_q;

    case (state_q)
      FETCH: begin
        req_c  = (q_count < CNT_W'(DEPTH));
        addr_c = fetch_pc_q;
        if (branch_taken) begin
          q_clear    = 1'b1;
          fetch_pc_d = branch_addr;
          if (req_c && !imem_ack) begin
            discard_addr_d = fetch_pc_q;
            state_d        = DISCARD;
          end
        end else begin
          q_pop = !freeze && !q_empty;
          if (req_c && imem_ack && (!q_full || q_pop)) begin
            q_push     = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end
      end

      DISCARD: begin
        // Hold the abandoned request until memory answers, then drop the word.
        req_c  = 1'b1;
        addr_c = discard_addr_q;
        if (imem_ack) state_d = FETCH;
        if (branch_taken) begin
          q_clear    = 1'b1;
          fetch_pc_d = branch_addr;
        end else begin
          q_pop = !freeze && !q_empty;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FETCH;
      fetch_pc_q     <= RESET_PC;
      discard_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (q_clear),
    .push      (q_push),
    .pop       (q_pop),
    .push_data (push_entry),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  assign imem_req        = req_c && !rst;
  assign imem_addr       = addr_c;
  assign pc_out          = q_empty ? NOP_WORD : q_head.pc;
  assign instruction_out = q_empty ? NOP_WORD : q_head.instr;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipe register.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch queue and presents {PC+4, instruction} to the pipe register.
- Handles variable memory latency, hazard freeze, and branch redirect, including discarding an in-flight fetch.

Parameters:
- DEPTH, 2, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- freeze  in  1  hazard stall; the queue head is held and not consumed.
- branch_taken  in  1  redirect request from EX; one-cycle pulse.
- branch_addr  in  32  redirect target; word-aligned.
- imem_req  out  1  memory request valid.
- imem_addr  out  32  request address; stable while imem_req=1 and no ack.
- imem_ack  in  1  response valid; may assert in the same cycle as imem_req (zero-wait memory).
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- pc_out  out  32  address of the presented instruction + 4.
- instruction_out  out  32  presented instruction.

Behaviour:
- Reset (async):
  - fetch_pc=RESET_PC, queue empty, state=FETCH, discard_addr=0.
  - imem_req=0 while rst is high.
  - pc_out=0 and instruction_out=0.
  - An outstanding memory transaction is abandoned; the memory model must tolerate this.
- States: FETCH, DISCARD.
- FETCH:
  - imem_req = (count<DEPTH); imem_addr = fetch_pc.
  - On req&ack: push {fetch_pc+4, imem_rdata}; fetch_pc += 4 (32-bit wrap).
  - Once req is raised it stays high until ack. Count can only fall while waiting, so this is guaranteed.
- DISCARD:
  - imem_req = 1; imem_addr = discard_addr.
  - On ack: data dropped, go to FETCH.
- Output:
  - Queue head is driven combinationally onto pc_out/instruction_out.
  - When the queue is empty, drive the bubble {0,0}, the same encoding the pipe register uses for flush.
- Pop: on clock edge when !freeze and queue non-empty.
- Throughput: with zero-wait memory, 1 instruction/cycle. Latency ack→output is 1 cycle (registered queue).
- Push and pop in the same edge: count unchanged. Full with pop and ack: both happen.
- Freeze with empty queue: bubble held; fetching continues until the queue is full.
- branch_taken (priority over freeze, ack, and pop):
  - Queue cleared; no push that edge.
  - fetch_pc <= branch_addr.
  - In FETCH with req&!ack: discard_addr <= fetch_pc, go to DISCARD.
  - In FETCH with req&ack, or with no req: the returned data is dropped, stay in FETCH.
  - In DISCARD: stay in DISCARD, discard_addr unchanged, fetch_pc <= branch_addr.
  - If ack arrives in the same cycle while in DISCARD: go to FETCH, fetch_pc <= branch_addr.
- Output during a branch cycle is don't-care; the pipe register flushes it.
- Count width is $clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.

Decomposition:
- Shared header/package holds:
  - state encodings FETCH=1'b0, DISCARD=1'b1;
  - NOP_WORD=32'h0;
  - PC_STEP=32'd4.
- One sub-module, fetch_queue:
  - synchronous FIFO of 64-bit entries with push, pop, and synchronous clear;
  - outputs count, full, empty, and head;
  - clear has priority over push.

Test Plan:
- Zero-wait memory (ack=req), RESET_PC=0, no freeze → after reset, pc_out/instruction_out = {4,mem[0]}, {8,mem[1]}, {12,mem[2]} on consecutive cycles. imem_addr is 0,4,8,...
- Memory latency 3 cycles → imem_addr=0 held for 3 cycles with req=1. Output is bubble {0,0} until 1 cycle after ack, then {4,mem[0]}.
- freeze=1 for 5 cycles with zero-wait memory → queue fills to 2. Req drops after addresses 0,4; output holds {4,mem[0]}. After release, outputs are {8,..} then {12,..} in order.
- Latency 3, branch_taken with branch_addr=0x100 one cycle after req to 0x8 → req stays at 0x8 until ack, data discarded. Next req is 0x100; first output is {0x104,mem[0x40]}, with no 0x8 word ever presented.
- Branch to 0x200 in the same cycle as an ack for 0xC and a pop → queue empty, 0xC dropped. Next imem_addr is 0x200.
- rst asserted mid-wait (req=1, no ack) → imem_req, pc_out, and instruction_out are 0 immediately (async). After release, fetching restarts at RESET_PC.
